// File: rtl/cp0_intr_ctrl.sv
// CP0 interrupt controller: edge-latched IRQs, masking/priority, safe-slot take in ID,
// STATUS/CAUSE/EPC register file and ERET return sequencing.
module cp0_intr_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               id_valid,
  input  logic               id_stall,
  input  logic [31:0]        pc_id,
  input  logic               eret_id,
  input  logic               cp0_wen,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic               flush_id,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               in_isr
);

  typedef enum logic [0:0] {StIdle, StArm} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, ip_q, ip_d, im_q, im_d, pend_vec;
  logic               ie_q, ie_d, in_isr_q, in_isr_d;
  logic [31:0]        epc_q, epc_d, vec_addr;
  logic [4:0]         idx_q, idx_d;
  logic [2:0]         sel;
  logic               pend_ok, slot_ok, take, eret;

  assign pend_vec = ip_q & im_q;
  assign pend_ok  = ie_q & (|pend_vec);
  assign slot_ok  = id_valid & ~id_stall & ~eret_id;
  assign take     = (state_q == StArm) & pend_ok & slot_ok;
  assign eret     = eret_id & id_valid & ~id_stall;
  assign vec_addr = VEC_BASE + 32'(sel) * VEC_STRIDE;

  // Scan from the top so the lowest pending index wins.
  always_comb begin
    sel = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend_vec[i]) sel = 3'(i);
    end
  end

  always_comb begin
    int_ack = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      int_ack[i] = take && (sel == 3'(i));
    end
  end

  assign jump_en   = take | eret;
  assign jump_addr = take ? vec_addr : (eret ? epc_q : 32'h0);
  assign flush_id  = take;
  assign in_isr    = in_isr_q;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      5'd12: begin
        cp0_rdata[8 +: NUM_IRQ] = im_q;
        cp0_rdata[0]            = ie_q;
      end
      5'd13: begin
        cp0_rdata[8 +: NUM_IRQ] = ip_q;
        cp0_rdata[6:2]          = idx_q;
      end
      5'd14:   cp0_rdata = epc_q;
      default: ;
    endcase
  end

  always_comb begin
    // A new edge sets IP even when the same source is being cleared by a take.
    ip_d     = (ip_q & ~int_ack) | (irq & ~irq_q);
    im_d     = im_q;
    ie_d     = ie_q;
    epc_d    = epc_q;
    idx_d    = idx_q;
    in_isr_d = in_isr_q;
    if (cp0_wen && cp0_addr == 5'd12) begin
      ie_d = cp0_wdata[0];
      im_d = cp0_wdata[8 +: NUM_IRQ];
    end
    if (cp0_wen && cp0_addr == 5'd14) epc_d = cp0_wdata;
    if (take) begin
      ie_d     = 1'b0;
      epc_d    = pc_id;
      idx_d    = 5'(sel);
      in_isr_d = 1'b1;
    end
    if (eret) begin
      ie_d     = 1'b1;
      in_isr_d = 1'b0;
    end
    state_d = state_q;
    case (state_q)
      StIdle:  if (pend_ok) state_d = StArm;
      StArm:   if (!pend_ok || take) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      irq_q    <= '0;
      ip_q     <= '0;
      im_q     <= '0;
      ie_q     <= 1'b0;
      epc_q    <= '0;
      idx_q    <= '0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq;
      ip_q     <= ip_d;
      im_q     <= im_d;
      ie_q     <= ie_d;
      epc_q    <= epc_d;
      idx_q    <= idx_d;
      in_isr_q <= in_isr_d;
    end
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl: take latency, priority, stalls, masking, ERET and reset.
module tb_cp0_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        id_valid, id_stall, eret_id, cp0_wen;
  logic [31:0] pc_id, cp0_wdata, cp0_rdata, jump_addr;
  logic [4:0]  cp0_addr;
  logic        jump_en, flush_id, in_isr;
  logic [3:0]  int_ack;

  int vectors = 0;
  int miscompares = 0;

  cp0_intr_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq       (irq),
    .id_valid  (id_valid),
    .id_stall  (id_stall),
    .pc_id     (pc_id),
    .eret_id   (eret_id),
    .cp0_wen   (cp0_wen),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (cp0_rdata),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .flush_id  (flush_id),
    .int_ack   (int_ack),
    .in_isr    (in_isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    cp0_wen = 1'b1; cp0_addr = addr; cp0_wdata = data;
    tick();
    cp0_wen = 1'b0;
  endtask

  task automatic no_jump(input string tag);
    #1;
    chk(tag, {30'h0, jump_en, flush_id}, 32'h0);
  endtask

  task automatic expect_take(input string tag, input logic [31:0] addr, input logic [3:0] ack);
    #1;
    chk({tag, "_en"}, {30'h0, jump_en, flush_id}, 32'h3);
    chk({tag, "_addr"}, jump_addr, addr);
    chk({tag, "_ack"}, 32'(int_ack), 32'(ack));
  endtask

  task automatic do_eret(input string tag, input logic [31:0] epc);
    eret_id = 1'b1;
    #1;
    chk({tag, "_en"}, {30'h0, jump_en, flush_id}, 32'h2);
    chk({tag, "_addr"}, jump_addr, epc);
    chk({tag, "_ack"}, 32'(int_ack), 32'h0);
    tick();
    eret_id = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; id_valid = 1'b1; id_stall = 1'b0; pc_id = '0;
    eret_id = 1'b0; cp0_wen = 1'b0; cp0_addr = '0; cp0_wdata = '0;
    #1;
    chk("rst_outs", {27'h0, jump_en, flush_id, in_isr, 2'b0}, 32'h0);
    chk("rst_ack", 32'(int_ack), 32'h0);
    rd("rst_status", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single source, take two cycles after the pulse
    mtc0(5'd12, 32'h0000_0F01);
    rd("t1_status", 5'd12, 32'h0000_0F01);
    irq = 4'b0100;
    no_jump("t1_c0");
    tick(); irq = '0;
    no_jump("t1_c1");
    rd("t1_ip", 5'd13, 32'h0000_0400);
    tick(); pc_id = 32'h0000_1000;
    expect_take("t1_take", 32'h0000_0120, 4'b0100);
    tick();
    no_jump("t1_after");
    chk("t1_in_isr", 32'(in_isr), 32'h1);
    rd("t1_epc", 5'd14, 32'h0000_1000);
    rd("t1_status_ie0", 5'd12, 32'h0000_0F00);
    rd("t1_cause", 5'd13, 32'h0000_0008);
    do_eret("t1_eret", 32'h0000_1000);
    chk("t1_isr_clr", 32'(in_isr), 32'h0);
    rd("t1_ie1", 5'd12, 32'h0000_0F01);

    // 2: simultaneous irq1/irq3, priority to 1
    irq = 4'b1010;
    tick(); irq = '0;
    no_jump("t2_c1");
    tick(); pc_id = 32'h0000_2000;
    expect_take("t2_take1", 32'h0000_0110, 4'b0010);
    tick();
    rd("t2_cause", 5'd13, 32'h0000_0804);
    // 5: ERET while irq3 still pending
    pc_id = 32'h0000_2004;
    do_eret("t5_eret", 32'h0000_2000);
    no_jump("t5_next");
    rd("t5_ie", 5'd12, 32'h0000_0F01);
    tick(); pc_id = 32'h0000_2100;
    expect_take("t2_take3", 32'h0000_0130, 4'b1000);
    tick();
    do_eret("t2_eret", 32'h0000_2100);

    // 3: stall holds the take in ARM
    irq = 4'b0100;
    tick(); irq = '0;
    tick(); id_stall = 1'b1;
    no_jump("t3_s0");
    tick(); no_jump("t3_s1");
    tick(); no_jump("t3_s2");
    tick(); id_stall = 1'b0; pc_id = 32'h0000_3000;
    expect_take("t3_take", 32'h0000_0120, 4'b0100);
    tick();
    rd("t3_epc", 5'd14, 32'h0000_3000);
    do_eret("t3_eret", 32'h0000_3000);

    // 4: masked source is visible but not taken until unmasked
    mtc0(5'd12, 32'h0000_0E01);
    irq = 4'b0001;
    tick(); irq = '0;
    tick();
    no_jump("t4_masked");
    rd("t4_ip", 5'd13, 32'h0000_0108);
    cp0_wen = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0F01;
    #1;
    chk("t4_nobypass", cp0_rdata, 32'h0000_0E01);
    no_jump("t4_w0");
    tick(); cp0_wen = 1'b0;
    no_jump("t4_w1");
    tick(); pc_id = 32'h0000_4000;
    expect_take("t4_take", 32'h0000_0100, 4'b0001);
    tick();
    rd("t4_cause", 5'd13, 32'h0000_0000);
    do_eret("t4_eret", 32'h0000_4000);

    // 6: reset while ARM waits for a slot
    irq = 4'b0010;
    tick(); irq = '0;
    tick(); id_valid = 1'b0;
    no_jump("t6_arm");
    tick();
    id_valid = 1'b1; rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {29'h0, jump_en, flush_id, in_isr}, 32'h0);
    chk("t6_rst_ack", 32'(int_ack), 32'h0);
    tick();
    rst_n = 1'b1;
    no_jump("t6_rel0");
    rd("t6_ip", 5'd13, 32'h0000_0000);
    rd("t6_status", 5'd12, 32'h0000_0000);
    tick();
    no_jump("t6_rel1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
